// File: rtl/alu_iq_pkg.sv
// Types for the ALU issue queue: operand slot, entry, occupancy width.
// Operand: {rdy, tag, data}; entry: {valid, op, tid, opnd[3]}.
package alu_iq_pkg;

  typedef struct packed {
    logic                           rdy;
    logic [tortoise_pkg::TID_W-1:0] tag;
    logic [63:0]                    data;
  } iq_opnd_t;

  typedef struct packed {
    logic                           valid;
    tortoise_pkg::alu_op_t          op;
    logic [tortoise_pkg::TID_W-1:0] tid;
    iq_opnd_t [2:0]                 opnd;
  } iq_entry_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tortoise_pkg.sv
// Core-wide types shared by the Tortoise pipeline.
// Holds the scoreboard trans-id width and the ALU operation encoding.
package tortoise_pkg;

  localparam int TID_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_ADDW,
    ALU_SUBW,
    ALU_SLLW,
    ALU_SRLW,
    ALU_SRAW,
    ALU_LUI
  } alu_op_t;

endpackage

// File: rtl/alu_iq_age_matrix.sv
// Age matrix for the ALU issue queue; picks the oldest requester.
// Ports: clk_i, rst_ni, flush_i, alloc_i/free_i/valid_i/req_i, gnt_o (one-hot).
module alu_iq_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [DEPTH-1:0] alloc_i,
  input  logic [DEPTH-1:0] free_i,
  input  logic [DEPTH-1:0] valid_i,
  input  logic [DEPTH-1:0] req_i,
  output logic [DEPTH-1:0] gnt_o
);

  // age_q[i][j] = 1: row i was dispatched before row j
  logic [DEPTH-1:0][DEPTH-1:0] age_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= '0;
    end else if (flush_i) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_i[j] && i != j)
            age_q[i][j] <= valid_i[i] && !free_i[i];
          else if (alloc_i[i] || free_i[i] || free_i[j])
            age_q[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      gnt_o[i] = req_i[i];
      for (int j = 0; j < DEPTH; j++)
        if (req_i[j] && age_q[j][i]) gnt_o[i] = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Reservation station for the shared ALU: holds entries until operands are
// ready (dispatch or writeback wakeup) and issues the oldest ready one.
// Ports: disp_* (valid/ready in), wb_* (wakeup), iss_* (valid/ready out),
// flush_i, occupancy_o. Option: TORTOISE_ALU_IQ_BYPASS_EN enables
// zero-latency issue from disp_* when the queue is empty.
module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TID_W = tortoise_pkg::TID_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  disp_valid_i,
  output logic                  disp_ready_o,
  input  tortoise_pkg::alu_op_t disp_op_i,
  input  logic [TID_W-1:0]      disp_tid_i,
  input  iq_opnd_t [2:0]        disp_opnd_i,
  input  logic                  wb_valid_i,
  input  logic [TID_W-1:0]      wb_tid_i,
  input  logic [63:0]           wb_data_i,
  output logic                  iss_valid_o,
  input  logic                  iss_ready_i,
  output tortoise_pkg::alu_op_t iss_op_o,
  output logic [TID_W-1:0]      iss_tid_o,
  output logic [2:0][63:0]      iss_opnd_o,
  output logic [occ_w(DEPTH)-1:0] occupancy_o
);

  localparam int OW = occ_w(DEPTH);

  iq_entry_t [DEPTH-1:0] ent_q;
  iq_opnd_t  [2:0]       disp_woke;
  iq_entry_t             s_ent;
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0]      rdy;
  logic [DEPTH-1:0]      gnt;
  logic [DEPTH-1:0]      sel;
  logic [DEPTH-1:0]      alloc;
  logic [DEPTH-1:0]      free;
  logic [DEPTH-1:0]      hold_q;
  logic                  hold_vld_q;
  logic [OW-1:0]         occ;
  logic                  stq_valid;
  logic                  fire;
  logic                  byp;
  logic                  found;

  function automatic iq_opnd_t wake(
    input iq_opnd_t         o,
    input logic             v,
    input logic [TID_W-1:0] t,
    input logic [63:0]      d
  );
    iq_opnd_t r;
    r = o;
    if (v && !o.rdy && o.tag == t) begin
      r.rdy  = 1'b1;
      r.data = d;
    end
    return r;
  endfunction

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid
             && ent_q[i].opnd[0].rdy
             && ent_q[i].opnd[1].rdy
             && ent_q[i].opnd[2].rdy;
      occ = occ + OW'(ent_q[i].valid);
    end
  end

  assign disp_ready_o = occ < OW'(DEPTH);
  assign occupancy_o  = occ;

  always_comb begin
    for (int k = 0; k < 3; k++)
      disp_woke[k] = wake(disp_opnd_i[k],
                          wb_valid_i, wb_tid_i, wb_data_i);
  end

`ifdef TORTOISE_ALU_IQ_BYPASS_EN
  assign byp = occ == '0 && disp_valid_i && iss_ready_i
            && !flush_i
            && disp_woke[0].rdy
            && disp_woke[1].rdy
            && disp_woke[2].rdy;
`else
  assign byp = 1'b0;
`endif

  // lowest-index free slot
  always_comb begin
    alloc = '0;
    found = 1'b0;
    if (disp_valid_i && disp_ready_o && !flush_i && !byp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!found && !ent_q[i].valid) begin
          alloc[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  alu_iq_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .alloc_i (alloc),
    .free_i  (free),
    .valid_i (vld),
    .req_i   (rdy),
    .gnt_o   (gnt)
  );

  // a stalled issue keeps its entry even if an older one wakes up
  assign sel       = hold_vld_q ? hold_q : gnt;
  assign stq_valid = |rdy && !flush_i;
  assign fire      = stq_valid && iss_ready_i;
  assign free      = sel & {DEPTH{fire}};

  always_comb begin
    s_ent = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) s_ent = ent_q[i];
  end

  always_comb begin
    iss_valid_o = stq_valid;
    iss_op_o    = tortoise_pkg::ALU_ADD;
    iss_tid_o   = '0;
    iss_opnd_o  = '0;
    if (stq_valid) begin
      iss_op_o  = s_ent.op;
      iss_tid_o = s_ent.tid;
      for (int k = 0; k < 3; k++)
        iss_opnd_o[k] = s_ent.opnd[k].data;
    end
`ifdef TORTOISE_ALU_IQ_BYPASS_EN
    if (byp) begin
      iss_valid_o = 1'b1;
      iss_op_o    = disp_op_i;
      iss_tid_o   = disp_tid_i;
      for (int k = 0; k < 3; k++)
        iss_opnd_o[k] = disp_woke[k].data;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          ent_q[i].valid <= 1'b1;
          ent_q[i].op    <= disp_op_i;
          ent_q[i].tid   <= disp_tid_i;
          ent_q[i].opnd  <= disp_woke;
        end else begin
          if (free[i]) ent_q[i].valid <= 1'b0;
          for (int k = 0; k < 3; k++)
            ent_q[i].opnd[k] <= wake(ent_q[i].opnd[k],
                                     wb_valid_i, wb_tid_i,
                                     wb_data_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= stq_valid && !iss_ready_i;
      hold_q     <= sel;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue against an age-ordered queue model.
// Directed cases pin the model with literal expectations.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;
  import tortoise_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            disp_valid;
  logic            disp_ready;
  alu_op_t         disp_op;
  logic [4:0]      disp_tid;
  iq_opnd_t [2:0]  disp_opnd;
  logic            wb_valid;
  logic [4:0]      wb_tid;
  logic [63:0]     wb_data;
  logic            iss_valid;
  logic            iss_ready;
  alu_op_t         iss_op;
  logic [4:0]      iss_tid;
  logic [2:0][63:0] iss_opnd;
  logic [2:0]      occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(4), .TID_W(5)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .disp_valid_i (disp_valid),
    .disp_ready_o (disp_ready),
    .disp_op_i    (disp_op),
    .disp_tid_i   (disp_tid),
    .disp_opnd_i  (disp_opnd),
    .wb_valid_i   (wb_valid),
    .wb_tid_i     (wb_tid),
    .wb_data_i    (wb_data),
    .iss_valid_o  (iss_valid),
    .iss_ready_i  (iss_ready),
    .iss_op_o     (iss_op),
    .iss_tid_o    (iss_tid),
    .iss_opnd_o   (iss_opnd),
    .occupancy_o  (occupancy)
  );

  typedef struct packed {
    int unsigned      seq;
    logic [3:0]       op;
    logic [4:0]       tid;
    logic [2:0]       rdy;
    logic [2:0][4:0]  tag;
    logic [2:0][63:0] data;
  } m_ent_t;

  m_ent_t      mq[$];
  int unsigned seq_n = 0;
  bit          held = 0;
  int unsigned held_seq = 0;
  bit          e_valid;
  bit          e_byp;
  m_ent_t      e_ent;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic m_ent_t mk_disp();
    m_ent_t e;
    e.seq = seq_n;
    e.op  = disp_op;
    e.tid = disp_tid;
    for (int k = 0; k < 3; k++) begin
      e.rdy[k]  = disp_opnd[k].rdy;
      e.tag[k]  = disp_opnd[k].tag;
      e.data[k] = disp_opnd[k].data;
      if (wb_valid && !e.rdy[k] && e.tag[k] == wb_tid) begin
        e.rdy[k]  = 1'b1;
        e.data[k] = wb_data;
      end
    end
    return e;
  endfunction

  task automatic eval();
    int sel;
    m_ent_t d;
    #1;
    sel = -1;
    e_valid = 0;
    e_byp = 0;
    e_ent = '0;
    if (held) begin
      foreach (mq[i]) if (mq[i].seq == held_seq) sel = i;
    end else begin
      foreach (mq[i])
        if (sel < 0 && mq[i].rdy == 3'b111) sel = i;
    end
    if (sel >= 0 && !flush) begin
      e_valid = 1;
      e_ent = mq[sel];
    end
`ifdef TORTOISE_ALU_IQ_BYPASS_EN
    d = mk_disp();
    if (mq.size() == 0 && disp_valid && !flush && iss_ready
        && d.rdy == 3'b111) begin
      e_valid = 1;
      e_byp = 1;
      e_ent = d;
    end
`else
    d = '0;
`endif
    chk("disp_ready", disp_ready, mq.size() < 4);
    chk("occupancy", occupancy, mq.size());
    chk("iss_valid", iss_valid, e_valid);
    if (e_valid) begin
      chk("iss_tid", iss_tid, e_ent.tid);
      chk("iss_op", iss_op, e_ent.op);
      for (int k = 0; k < 3; k++)
        chk("iss_opnd", iss_opnd[k], e_ent.data[k]);
    end
  endtask

  task automatic adv();
    bit acc;
    m_ent_t t;
    acc = disp_valid && mq.size() < 4 && !e_byp;
    if (flush) begin
      mq.delete();
      held = 0;
    end else begin
      foreach (mq[i]) begin
        t = mq[i];
        for (int k = 0; k < 3; k++)
          if (wb_valid && !t.rdy[k] && t.tag[k] == wb_tid) begin
            t.rdy[k]  = 1'b1;
            t.data[k] = wb_data;
          end
        mq[i] = t;
      end
      if (e_valid && iss_ready && !e_byp) begin
        for (int i = mq.size() - 1; i >= 0; i--)
          if (mq[i].seq == e_ent.seq) mq.delete(i);
      end
      if (acc) begin
        t = mk_disp();
        mq.push_back(t);
      end
      held = e_valid && !iss_ready;
      held_seq = e_ent.seq;
    end
    seq_n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    disp_valid = 0;
    flush = 0;
    wb_valid = 0;
    wb_tid = '0;
    wb_data = '0;
    iss_ready = 0;
    disp_op = ALU_ADD;
    disp_tid = '0;
    disp_opnd = '0;
  endtask

  task automatic put(input logic [4:0] tid, input logic [63:0] d0,
                     input logic [63:0] d1, input logic [63:0] d2);
    disp_valid = 1;
    disp_op = ALU_ADD;
    disp_tid = tid;
    disp_opnd[0] = '{rdy: 1'b1, tag: 5'd0, data: d0};
    disp_opnd[1] = '{rdy: 1'b1, tag: 5'd0, data: d1};
    disp_opnd[2] = '{rdy: 1'b1, tag: 5'd0, data: d2};
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_tid", iss_tid, 0);
    chk("rst_opnd", iss_opnd, 0);
    rst_n = 1;
    @(negedge clk);

    // single ready entry
    idle_in();
    put(3, 5, 7, 0);
    iss_ready = 1;
    eval();
`ifdef TORTOISE_ALU_IQ_BYPASS_EN
    chk("byp_valid", iss_valid, 1);
    chk("byp_tid", iss_tid, 3);
    chk("byp_occ", occupancy, 0);
`endif
    adv();
    disp_valid = 0;
    eval();
`ifndef TORTOISE_ALU_IQ_BYPASS_EN
    chk("t1_valid", iss_valid, 1);
    chk("t1_tid", iss_tid, 3);
    chk("t1_op0", iss_opnd[0], 5);
    chk("t1_op1", iss_opnd[1], 7);
    chk("t1_op2", iss_opnd[2], 0);
    chk("t1_occ", occupancy, 1);
`endif
    adv();
    eval();
    chk("t1_occ0", occupancy, 0);
    adv();

    // younger ready entry overtakes a waiting one
    idle_in();
    iss_ready = 1;
    put(1, 0, 'h11, 'h22);
    disp_opnd[0] = '{rdy: 1'b0, tag: 5'd9, data: 64'd0};
    eval();
    adv();
    put(2, 1, 2, 3);
    eval();
    chk("t2_wait", iss_valid, 0);
    adv();
    disp_valid = 0;
    wb_valid = 1;
    wb_tid = 9;
    wb_data = 'hAA;
    eval();
    chk("t2_first", iss_tid, 2);
    adv();
    wb_valid = 0;
    eval();
    chk("t2_second", iss_tid, 1);
    chk("t2_woke", iss_opnd[0], 'hAA);
    adv();
    eval();
    chk("t2_occ0", occupancy, 0);
    adv();

    // fill, stall, drain in order
    idle_in();
    for (int i = 0; i < 4; i++) begin
      put(5'(10 + i), 64'(i), 0, 0);
      eval();
      adv();
    end
    put(20, 9, 9, 9);
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("t3_full", disp_ready, 0);
      chk("t3_hold", iss_tid, 10);
      adv();
    end
    disp_valid = 0;
    iss_ready = 1;
    for (int i = 0; i < 4; i++) begin
      eval();
      chk("t3_order", iss_tid, 5'(10 + i));
      adv();
    end
    eval();
    chk("t3_occ0", occupancy, 0);
    adv();

    // wakeup in the dispatch cycle
    idle_in();
    put(4, 0, 1, 2);
    disp_opnd[0] = '{rdy: 1'b0, tag: 5'd5, data: 64'd0};
    wb_valid = 1;
    wb_tid = 5;
    wb_data = 'h1234;
    eval();
    adv();
    idle_in();
    iss_ready = 1;
    eval();
    chk("t4_valid", iss_valid, 1);
    chk("t4_tid", iss_tid, 4);
    chk("t4_data", iss_opnd[0], 'h1234);
    adv();

    // flush with a dispatch in the same cycle
    idle_in();
    for (int i = 0; i < 3; i++) begin
      put(5'(21 + i), 1, 1, 1);
      eval();
      adv();
    end
    put(30, 3, 3, 3);
    flush = 1;
    iss_ready = 1;
    eval();
    chk("t5_kill", iss_valid, 0);
    adv();
    idle_in();
    iss_ready = 1;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("t5_occ", occupancy, 0);
      chk("t5_none", iss_valid, 0);
      adv();
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      flush = $urandom_range(0, 59) == 0;
      disp_valid = $urandom_range(0, 1) == 1;
      disp_op = alu_op_t'($urandom_range(0, 15));
      disp_tid = 5'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        disp_opnd[k].rdy = $urandom_range(0, 2) != 0;
        disp_opnd[k].tag = 5'($urandom_range(0, 7));
        disp_opnd[k].data = {$urandom, $urandom};
      end
      wb_valid = $urandom_range(0, 1) == 1;
      wb_tid = 5'($urandom_range(0, 7));
      wb_data = {$urandom, $urandom};
      iss_ready = $urandom_range(0, 3) != 0;
      eval();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
